// File: rtl/cd_host_comm_if.sv
// rtl/cd_host_comm_if.sv - CDD nibble link between host logic and the CDD MCU
interface cd_host_comm_if;
    logic       CD_nIRQ;
    logic       CDCK;
    logic [3:0] CDD_DIN;
    logic       HOCK;
    logic [3:0] CDD_DOUT;

    modport master (
        input  CD_nIRQ,
        input  CDCK,
        input  CDD_DIN,
        output HOCK,
        output CDD_DOUT
    );

    modport slave (
        output CD_nIRQ,
        output CDCK,
        output CDD_DIN,
        input  HOCK,
        input  CDD_DOUT
    );
endinterface

// File: rtl/cd_host_comm.sv
// rtl/cd_host_comm.sv - host side of the CDD exchange: 10-nibble status rx, 10-nibble command tx
module cd_host_comm #(
    parameter int TIMEOUT = 4095,
    parameter int SETUP   = 96
) (
    input  logic          CLK_12M,
    input  logic          RESET,
    cd_host_comm_if.master cdd,
    input  logic          CMD_WR,
    input  logic [35:0]   CMD_NIB,
    output logic          CMD_PEND,
    output logic [39:0]   STATUS,
    output logic          STATUS_VALID,
    output logic          STATUS_CKERR,
    output logic          XFER_DONE,
    output logic          TIMEOUT_ERR
);

    typedef enum logic [2:0] {IDLE, RX_LO, RX_HI, TX_SU, TX_HI, TX_LO} state_t;

    localparam logic [11:0] TMO     = 12'(TIMEOUT);
    localparam logic [11:0] SU_LAST = 12'(SETUP - 1);

    state_t      state, state_nxt;
    logic [1:0]  irq_sync, cdck_sync;
    logic        irq_s, cdck_s;
    logic [3:0]  idx, idx_nxt;
    logic [11:0] tmr, tmr_nxt;
    logic        hock, hock_nxt;
    logic [3:0]  dout;
    logic [35:0] cmd_nib;
    logic        cmd_used;
    logic [39:0] rx_buf, tx_frame, new_frame;
    logic [35:0] base_frame;
    logic        cap, commit, load, drive, done, abort;

    function automatic logic [3:0] ck9(input logic [35:0] n);
        logic [3:0] s;
        s = 4'h5;
        for (int k = 0; k < 9; k++) s = s + n[k*4 +: 4];
        return ~s;
    endfunction

    assign irq_s        = irq_sync[1];
    assign cdck_s       = cdck_sync[1];
    assign cdd.HOCK     = hock;
    assign cdd.CDD_DOUT = dout;

    // The frame is built from what was pending before any same-cycle CMD_WR.
    assign base_frame = CMD_PEND ? cmd_nib : 36'd0;
    assign new_frame  = {ck9(base_frame), base_frame};

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        hock_nxt  = hock;
        cap       = 1'b0;
        commit    = 1'b0;
        load      = 1'b0;
        drive     = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (!irq_s) begin
                    hock_nxt  = 1'b0;
                    idx_nxt   = 4'd0;
                    state_nxt = RX_LO;
                end
            end
            RX_LO: begin
                if (!cdck_s) begin
                    cap       = 1'b1;
                    hock_nxt  = 1'b1;
                    state_nxt = RX_HI;
                end else if (tmr == TMO) begin
                    abort = 1'b1;
                end
            end
            RX_HI: begin
                if (cdck_s) begin
                    hock_nxt = 1'b0;
                    if (idx != 4'd9) begin
                        idx_nxt   = idx + 4'd1;
                        state_nxt = RX_LO;
                    end else begin
                        commit    = 1'b1;
                        load      = 1'b1;
                        idx_nxt   = 4'd0;
                        state_nxt = TX_SU;
                    end
                end else if (tmr == TMO) begin
                    abort = 1'b1;
                end
            end
            TX_SU: begin
                if (tmr == SU_LAST) begin
                    hock_nxt  = 1'b1;
                    state_nxt = TX_HI;
                end else if (tmr == TMO) begin
                    abort = 1'b1;
                end
            end
            TX_HI: begin
                if (cdck_s) begin
                    hock_nxt  = 1'b0;
                    state_nxt = TX_LO;
                end else if (tmr == TMO) begin
                    abort = 1'b1;
                end
            end
            TX_LO: begin
                if (!cdck_s) begin
                    if (idx != 4'd9) begin
                        idx_nxt   = idx + 4'd1;
                        drive     = 1'b1;
                        state_nxt = TX_SU;
                    end else begin
                        hock_nxt  = 1'b1;
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (tmr == TMO) begin
                    abort = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            hock_nxt  = 1'b1;
            state_nxt = IDLE;
        end
        if (state_nxt != state || state == IDLE) tmr_nxt = 12'd0;
        else                                     tmr_nxt = tmr + 12'd1;
    end

    always_ff @(posedge CLK_12M or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            irq_sync     <= 2'b11;
            cdck_sync    <= 2'b11;
            idx          <= 4'd0;
            tmr          <= 12'd0;
            hock         <= 1'b1;
            dout         <= 4'd0;
            cmd_nib      <= 36'd0;
            cmd_used     <= 1'b0;
            rx_buf       <= 40'd0;
            tx_frame     <= 40'd0;
            CMD_PEND     <= 1'b0;
            STATUS       <= 40'd0;
            STATUS_VALID <= 1'b0;
            STATUS_CKERR <= 1'b0;
            XFER_DONE    <= 1'b0;
            TIMEOUT_ERR  <= 1'b0;
        end else begin
            irq_sync     <= {irq_sync[0], cdd.CD_nIRQ};
            cdck_sync    <= {cdck_sync[0], cdd.CDCK};
            state        <= state_nxt;
            idx          <= idx_nxt;
            tmr          <= tmr_nxt;
            hock         <= hock_nxt;
            STATUS_VALID <= commit;
            XFER_DONE    <= done;
            TIMEOUT_ERR  <= abort;
            if (cap) rx_buf[{idx, 2'b00} +: 4] <= cdd.CDD_DIN;
            if (commit) begin
                STATUS       <= rx_buf;
                STATUS_CKERR <= rx_buf[39:36] != ck9(rx_buf[35:0]);
            end
            if (load) begin
                tx_frame <= new_frame;
                dout     <= new_frame[3:0];
            end else if (drive) begin
                dout <= tx_frame[{idx_nxt, 2'b00} +: 4];
            end
            if (load)               cmd_used <= CMD_PEND;
            else if (done || abort) cmd_used <= 1'b0;
            // A command consumed by an aborted transmit goes back to pending.
            if (CMD_WR) begin
                cmd_nib  <= CMD_NIB;
                CMD_PEND <= 1'b1;
            end else if (load) begin
                CMD_PEND <= 1'b0;
            end else if (abort && cmd_used) begin
                CMD_PEND <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cd_host_comm.sv
// tb/tb_cd_host_comm.sv - bench for cd_host_comm with a CDD responder and frame-level reference model
module tb_cd_host_comm;

    logic        CLK_12M = 1'b0;
    logic        RESET   = 1'b1;
    logic        CMD_WR  = 1'b0;
    logic [35:0] CMD_NIB = 36'd0;
    logic        CMD_PEND;
    logic [39:0] STATUS;
    logic        STATUS_VALID, STATUS_CKERR, XFER_DONE, TIMEOUT_ERR;

    cd_host_comm_if cdd ();

    cd_host_comm #(.TIMEOUT(4095), .SETUP(96)) dut (
        .CLK_12M      (CLK_12M),
        .RESET        (RESET),
        .cdd          (cdd),
        .CMD_WR       (CMD_WR),
        .CMD_NIB      (CMD_NIB),
        .CMD_PEND     (CMD_PEND),
        .STATUS       (STATUS),
        .STATUS_VALID (STATUS_VALID),
        .STATUS_CKERR (STATUS_CKERR),
        .XFER_DONE    (XFER_DONE),
        .TIMEOUT_ERR  (TIMEOUT_ERR)
    );

    always #5 CLK_12M = ~CLK_12M;

    int tests = 0;
    int fails = 0;
    int n_valid = 0, n_done = 0, n_tout = 0;

    // reference model state
    bit          exp_pend = 0;
    int          exp_cmd[9];
    logic [39:0] exp_status = 40'd0;
    logic        exp_ckerr = 1'b0;

    always @(negedge CLK_12M) begin
        if (STATUS_VALID) n_valid++;
        if (XFER_DONE)    n_done++;
        if (TIMEOUT_ERR)  n_tout++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cksum(input int n[10]);
        int s;
        s = 5;
        for (int k = 0; k < 9; k++) s += n[k];
        return 15 - (s % 16);
    endfunction

    function automatic logic [39:0] pack10(input int n[10]);
        logic [39:0] r;
        r = 40'd0;
        for (int k = 0; k < 10; k++) r = r | (40'(n[k] & 15) << (4 * k));
        return r;
    endfunction

    task automatic wait_hock(input logic v, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge CLK_12M);
            if (cdd.HOCK === v) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("hock_wait", {63'd0, cdd.HOCK}, {63'd0, v});
    endtask

    task automatic write_cmd(input int c[9]);
        @(negedge CLK_12M);
        for (int k = 0; k < 9; k++) CMD_NIB[k*4 +: 4] = 4'(c[k]);
        CMD_WR = 1'b1;
        @(negedge CLK_12M);
        CMD_WR = 1'b0;
        exp_pend = 1;
        for (int k = 0; k < 9; k++) exp_cmd[k] = c[k];
    endtask

    // mode 0: full exchange; 1: stop after rx with CDCK high; 2: stop in TX_HI with CDCK low
    task automatic run_exchange(input int st[10], input int mode, output int tx[10], output bit ok);
        for (int k = 0; k < 10; k++) tx[k] = -1;
        cdd.CD_nIRQ = 1'b0;
        wait_hock(1'b0, 50, ok);
        cdd.CD_nIRQ = 1'b1;
        if (!ok) return;
        for (int i = 0; i < 10; i++) begin
            cdd.CDD_DIN = 4'(st[i]);
            cdd.CDCK    = 1'b0;
            wait_hock(1'b1, 50, ok);
            if (!ok) return;
            cdd.CDCK = 1'b1;
            wait_hock(1'b0, 50, ok);
            if (!ok) return;
        end
        if (mode == 1) return;
        if (mode == 2) begin
            cdd.CDCK = 1'b0;
            wait_hock(1'b1, 200, ok);
            return;
        end
        for (int i = 0; i < 10; i++) begin
            wait_hock(1'b1, 200, ok);
            if (!ok) return;
            tx[i]    = int'(cdd.CDD_DOUT);
            cdd.CDCK = 1'b1;
            wait_hock(1'b0, 50, ok);
            if (!ok) return;
            cdd.CDCK = 1'b0;
        end
        wait_hock(1'b1, 50, ok);
        cdd.CDCK = 1'b1;
    endtask

    task automatic model_frame(input int st[10], output int fr[10]);
        for (int k = 0; k < 9; k++) fr[k] = exp_pend ? exp_cmd[k] : 0;
        fr[9] = cksum(fr);
        exp_pend   = 0;
        exp_status = pack10(st);
        exp_ckerr  = (st[9] != cksum(st));
    endtask

    task automatic full_exchange(input string tag, input int st[10]);
        int  tx[10];
        int  fr[10];
        int  v0, d0;
        bit  ok;
        check({tag, "_pend_before"}, {63'd0, CMD_PEND}, {63'd0, exp_pend});
        v0 = n_valid;
        d0 = n_done;
        model_frame(st, fr);
        run_exchange(st, 0, tx, ok);
        repeat (3) @(negedge CLK_12M);
        check({tag, "_status"}, {24'd0, STATUS}, {24'd0, exp_status});
        check({tag, "_ckerr"}, {63'd0, STATUS_CKERR}, {63'd0, exp_ckerr});
        check({tag, "_valid_pulses"}, 64'(n_valid - v0), 64'd1);
        check({tag, "_done_pulses"}, 64'(n_done - d0), 64'd1);
        check({tag, "_pend_after"}, {63'd0, CMD_PEND}, {63'd0, exp_pend});
        check({tag, "_hock_idle"}, {63'd0, cdd.HOCK}, 64'd1);
        for (int k = 0; k < 10; k++)
            check($sformatf("%s_tx%0d", tag, k), 64'(tx[k]), 64'(fr[k]));
    endtask

    initial begin
        int  st[10];
        int  cmd[9];
        int  tx[10];
        int  fr[10];
        int  v0, t0, d0, cyc;
        bit  ok;

        cdd.CD_nIRQ = 1'b1;
        cdd.CDCK    = 1'b1;
        cdd.CDD_DIN = 4'd0;

        repeat (3) @(negedge CLK_12M);
        check("rst_hock", {63'd0, cdd.HOCK}, 64'd1);
        check("rst_dout", {60'd0, cdd.CDD_DOUT}, 64'd0);
        check("rst_pend", {63'd0, CMD_PEND}, 64'd0);
        check("rst_status", {24'd0, STATUS}, 64'd0);
        check("rst_flags", {60'd0, STATUS_VALID, STATUS_CKERR, XFER_DONE, TIMEOUT_ERR}, 64'd0);
        RESET = 1'b0;
        repeat (3) @(negedge CLK_12M);

        // status 1,2,3,4 with a correct checksum, NOP transmitted
        st = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0};
        st[9] = cksum(st);
        full_exchange("t1", st);

        // command n0=2, n3=4
        cmd = '{2, 0, 0, 4, 0, 0, 0, 0, 0};
        write_cmd(cmd);
        st = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 0};
        st[9] = cksum(st);
        full_exchange("t2", st);

        // corrupted status checksum
        st = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0};
        st[9] = (cksum(st) + 5) % 16;
        full_exchange("t4", st);

        // randomized exchanges
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 9; k++) st[k] = int'($urandom_range(0, 15));
            st[9] = ($urandom_range(0, 1) == 0) ? cksum(st) : int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 9; k++) cmd[k] = int'($urandom_range(0, 15));
                write_cmd(cmd);
            end
            full_exchange($sformatf("rnd%0d", r), st);
        end

        // timeout in RX_LO: CDCK never drops, pending command untouched
        cmd = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        write_cmd(cmd);
        v0 = n_valid;
        t0 = n_tout;
        cdd.CD_nIRQ = 1'b0;
        wait_hock(1'b0, 50, ok);
        cdd.CD_nIRQ = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 5000; c++) begin
            @(negedge CLK_12M);
            if (TIMEOUT_ERR) begin
                cyc = c;
                break;
            end
        end
        check("to_rx_window", {63'd0, (cyc >= 4094 && cyc <= 4098)}, 64'd1);
        check("to_rx_hock", {63'd0, cdd.HOCK}, 64'd1);
        repeat (2) @(negedge CLK_12M);
        check("to_rx_pulses", 64'(n_tout - t0), 64'd1);
        check("to_rx_valid", 64'(n_valid - v0), 64'd0);
        check("to_rx_status", {24'd0, STATUS}, {24'd0, exp_status});
        check("to_rx_pend", {63'd0, CMD_PEND}, 64'd1);

        // timeout in TX_LO: frame consumed, status committed, command restored
        for (int k = 0; k < 10; k++) st[k] = int'($urandom_range(0, 15));
        t0 = n_tout;
        d0 = n_done;
        model_frame(st, fr);
        run_exchange(st, 1, tx, ok);
        exp_pend = 1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge CLK_12M);
            if (TIMEOUT_ERR) break;
        end
        repeat (2) @(negedge CLK_12M);
        check("to_tx_pulses", 64'(n_tout - t0), 64'd1);
        check("to_tx_done", 64'(n_done - d0), 64'd0);
        check("to_tx_status", {24'd0, STATUS}, {24'd0, exp_status});
        check("to_tx_pend", {63'd0, CMD_PEND}, 64'd1);
        check("to_tx_hock", {63'd0, cdd.HOCK}, 64'd1);

        // restored command is sent by the next exchange
        st = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
        st[9] = cksum(st);
        full_exchange("resend", st);

        // reset while waiting in TX_HI
        cmd = '{7, 1, 2, 3, 4, 5, 6, 7, 8};
        write_cmd(cmd);
        for (int k = 0; k < 10; k++) st[k] = int'($urandom_range(0, 15));
        model_frame(st, fr);
        run_exchange(st, 2, tx, ok);
        repeat (5) @(negedge CLK_12M);
        check("txhi_dout", {60'd0, cdd.CDD_DOUT}, 64'(fr[0]));
        check("txhi_hock", {63'd0, cdd.HOCK}, 64'd1);
        #2 RESET = 1'b1;
        #1;
        check("arst_hock", {63'd0, cdd.HOCK}, 64'd1);
        check("arst_dout", {60'd0, cdd.CDD_DOUT}, 64'd0);
        check("arst_pend", {63'd0, CMD_PEND}, 64'd0);
        check("arst_status", {24'd0, STATUS}, 64'd0);
        exp_pend   = 0;
        exp_status = 40'd0;
        exp_ckerr  = 1'b0;
        @(negedge CLK_12M);
        RESET    = 1'b0;
        cdd.CDCK = 1'b1;
        repeat (3) @(negedge CLK_12M);

        st = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 0};
        st[9] = cksum(st);
        full_exchange("post_rst", st);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench time limit");
    end

endmodule
